ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 21 ++
 rtl/refresh_credit.sv | 47 ++++
 rtl/ram_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default constants for the SDRAM port arbiter.
package ram_arb_pkg;

   localparam int unsigned ADDR_W_DEF      = 32;
   localparam int unsigned REFRESH_MAX_DEF = 8;

   // Arbiter sequencing states
   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitRd,
      StRefresh
   } arb_state_t;

   // Which requester owns the command currently in flight
   typedef enum logic {
      OwnSpi,
      OwnHost
   } arb_owner_t;

endpackage

// File: rtl/refresh_credit.sv
// Saturating count of refresh ticks not yet serviced, plus pending/forced flags.
module refresh_credit
   import ram_arb_pkg::*;
#(
   parameter int unsigned REFRESH_MAX = REFRESH_MAX_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic i_tick,
   input  logic i_accept,
   output logic o_pending,
   output logic o_forced
);

   localparam int unsigned CNT_W = $clog2(REFRESH_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_MAX);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_nxt;

   // Tick and accept in the same cycle cancel; count clamps at both ends
   always_comb begin
      w_count_nxt = r_count;
      if (i_tick && !i_accept) begin
         if (r_count != CNT_MAX) begin
            w_count_nxt = r_count + CNT_W'(1);
         end
      end else if (!i_tick && i_accept) begin
         if (r_count != '0) begin
            w_count_nxt = r_count - CNT_W'(1);
         end
      end
   end

   // Counter register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else begin
         r_count <= w_count_nxt;
      end
   end

   assign o_pending = (r_count != '0);
   assign o_forced  = (r_count == CNT_MAX);

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a single SDRAM command port between the SPI flash engine, the host
// port and deferred refreshes. One command is in flight at a time.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned REFRESH_MAX = REFRESH_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset,
   // SPI flash engine
   input  logic              spi_critical,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic              spi_read_enable,
   output logic [7:0]        spi_read_data,
   output logic              spi_read_valid,
   // Host port
   input  logic              host_req,
   input  logic              host_wr,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [7:0]        host_wdata,
   output logic              host_ack,
   output logic [7:0]        host_rdata,
   // Refresh timer
   input  logic              refresh_tick,
   // SDRAM controller
   output logic              mem_cmd_valid,
   input  logic              mem_cmd_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wdata,
   output logic              mem_refresh,
   input  logic              mem_rd_valid,
   input  logic [7:0]        mem_rd_data
);

   arb_state_t        r_state, w_state_nxt;
   arb_owner_t        r_owner, w_owner_nxt;
   logic [ADDR_W-1:0] r_addr, w_addr_nxt;
   logic              r_we, w_we_nxt;
   logic [7:0]        r_wdata, w_wdata_nxt;
   logic              r_spi_pend, w_spi_pend_nxt;
   logic [ADDR_W-1:0] r_spi_addr, w_spi_addr_nxt;
   logic              r_host_wack, w_host_wack_nxt;

   logic w_spi_grant;
   logic w_ref_pend;
   logic w_ref_forced;
   logic w_ref_accept;
   logic w_rd_hit;

   assign w_ref_accept = (r_state == StRefresh) && mem_cmd_ready;
   assign w_rd_hit     = (r_state == StWaitRd) && mem_rd_valid;

   refresh_credit #(
      .REFRESH_MAX (REFRESH_MAX)
   ) u_credit (
      .clk       (clk),
      .reset     (reset),
      .i_tick    (refresh_tick),
      .i_accept  (w_ref_accept),
      .o_pending (w_ref_pend),
      .o_forced  (w_ref_forced)
   );

   // Grant arbitration in idle, command handshake and read-return sequencing
   always_comb begin
      w_state_nxt     = r_state;
      w_owner_nxt     = r_owner;
      w_addr_nxt      = r_addr;
      w_we_nxt        = r_we;
      w_wdata_nxt     = r_wdata;
      w_spi_grant     = 1'b0;
      w_host_wack_nxt = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_ref_forced) begin
               w_state_nxt = StRefresh;
               w_addr_nxt  = '0;
               w_we_nxt    = 1'b0;
               w_wdata_nxt = '0;
            end else if (r_spi_pend) begin
               w_state_nxt = StIssue;
               w_owner_nxt = OwnSpi;
               w_addr_nxt  = r_spi_addr;
               w_we_nxt    = 1'b0;
               w_wdata_nxt = '0;
               w_spi_grant = 1'b1;
            end else if (w_ref_pend && !spi_critical) begin
               w_state_nxt = StRefresh;
               w_addr_nxt  = '0;
               w_we_nxt    = 1'b0;
               w_wdata_nxt = '0;
            end else if (host_req && !spi_critical && !r_host_wack) begin
               // r_host_wack blocks the still-held request of a write being acked
               w_state_nxt = StIssue;
               w_owner_nxt = OwnHost;
               w_addr_nxt  = host_addr;
               w_we_nxt    = host_wr;
               w_wdata_nxt = host_wdata;
            end
         end
         StIssue: begin
            if (mem_cmd_ready) begin
               if (r_we) begin
                  w_state_nxt     = StIdle;
                  w_host_wack_nxt = (r_owner == OwnHost);
               end else begin
                  w_state_nxt = StWaitRd;
               end
            end
         end
         StWaitRd: begin
            if (mem_rd_valid) begin
               w_state_nxt = StIdle;
            end
         end
         StRefresh: begin
            if (mem_cmd_ready) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // One-deep SPI slot: a new request overwrites, and beats a same-cycle grant
   always_comb begin
      w_spi_pend_nxt = r_spi_pend;
      w_spi_addr_nxt = r_spi_addr;
      if (spi_read_enable) begin
         w_spi_pend_nxt = 1'b1;
         w_spi_addr_nxt = spi_addr;
      end else if (w_spi_grant) begin
         w_spi_pend_nxt = 1'b0;
      end
   end

   // State and command-field registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StIdle;
         r_owner     <= OwnSpi;
         r_addr      <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
         r_spi_pend  <= 1'b0;
         r_spi_addr  <= '0;
         r_host_wack <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_owner     <= w_owner_nxt;
         r_addr      <= w_addr_nxt;
         r_we        <= w_we_nxt;
         r_wdata     <= w_wdata_nxt;
         r_spi_pend  <= w_spi_pend_nxt;
         r_spi_addr  <= w_spi_addr_nxt;
         r_host_wack <= w_host_wack_nxt;
      end
   end

   // Command port driven straight from registered state and fields
   always_comb begin
      mem_cmd_valid = (r_state == StIssue) || (r_state == StRefresh);
      mem_refresh   = (r_state == StRefresh);
      mem_addr      = r_addr;
      mem_we        = r_we;
      mem_wdata     = r_wdata;
   end

   // Read data is steered combinationally to whoever owns the outstanding read
   always_comb begin
      spi_read_valid = w_rd_hit && (r_owner == OwnSpi);
      spi_read_data  = spi_read_valid ? mem_rd_data : 8'h00;
      host_ack       = r_host_wack || (w_rd_hit && (r_owner == OwnHost));
      host_rdata     = (w_rd_hit && (r_owner == OwnHost)) ? mem_rd_data : 8'h00;
   end

endmodule
